// File: rtl/bram_port_pkg.sv
// ---------------------------------------------------------------------------
// bram_port_pkg
//   Shared definitions for the BRAM port-A command master.
//   - state_t   : master FSM states
//   - params_ok : elaboration-time sanity check of the read-latency / response
//                 FIFO sizing pair. The FIFO must hold every beat that can be
//                 in flight, and its depth must be a power of two.
// ---------------------------------------------------------------------------
package bram_port_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR    = 2'd1,
        RD    = 2'd2,
        DRAIN = 2'd3
    } state_t;

    function automatic bit params_ok(input int rd_lat, input int rsp_depth);
        bit lat_ok;
        bit depth_ok;
        bit pow2_ok;
        lat_ok   = (rd_lat == 1) || (rd_lat == 2);
        depth_ok = rsp_depth >= (rd_lat + 1);
        pow2_ok  = (rsp_depth > 0) && ((rsp_depth & (rsp_depth - 1)) == 0);
        return lat_ok && depth_ok && pow2_ok;
    endfunction

endpackage

// File: rtl/bram_port_master_rsp_fifo.sv
// ---------------------------------------------------------------------------
// rsp_fifo
//   Synchronous first-word-fall-through FIFO for read responses.
//   Ports:
//     clk, rst_n        clock / asynchronous active-low reset
//     push, push_data   write side (caller guarantees no overflow)
//     pop               read side (caller guarantees not empty)
//     pop_data          current head entry
//     empty             no entries stored
//     count             number of entries stored (0..DEPTH)
//   Push and pop in the same cycle are legal at any occupancy.
// ---------------------------------------------------------------------------
module rsp_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   cnt;

    // Pointers and occupancy are control state and are cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            cnt <= cnt + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

    // Storage carries data only; stale contents are unreachable after reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign pop_data = mem[rd_ptr];
    assign empty    = (cnt == '0);
    assign count    = cnt;

endmodule

// File: rtl/bram_port_master.sv
// ---------------------------------------------------------------------------
// bram_port_master
//   Command-driven initiator for port A of a single-port BRAM. Write bursts
//   stream data from the wr_* channel into the BRAM; read bursts issue
//   addresses under a credit scheme and return data on the rsp_* stream.
//   Ports:
//     clka_0, rsta_n_0              clock / asynchronous active-low reset
//     cmd_valid/ready/we/addr/len   burst command (beats = cmd_len + 1)
//     wr_valid/ready/data           write beat stream
//     rsp_valid/ready/data/last     read response stream
//     busy                          FSM active or responses still queued
//     addra_0/dina_0/wea_0          registered BRAM port drive
//     douta_0                       BRAM read data (RD_LAT cycles latency)
// ---------------------------------------------------------------------------
module bram_port_master
    import bram_port_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 16,
    parameter int LEN_W     = 4,
    parameter int RD_LAT    = 1,
    parameter int RSP_DEPTH = 4
) (
    input  logic              clka_0,
    input  logic              rsta_n_0,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              busy,
    output logic [ADDR_W-1:0] addra_0,
    output logic [DATA_W-1:0] dina_0,
    output logic              wea_0,
    input  logic [DATA_W-1:0] douta_0
);

    if (!params_ok(RD_LAT, RSP_DEPTH)) begin : g_bad_params
        $error("bram_port_master: RD_LAT must be 1 or 2 and RSP_DEPTH a power of two >= RD_LAT+1");
    end

    // Stage 0 of the in-flight pipe lines up with addra_0; stage RD_LAT lines
    // up with the cycle in which douta_0 holds that address's data.
    localparam int PIPE_N = RD_LAT + 1;
    localparam int CNT_W  = $clog2(RSP_DEPTH) + 1;

    state_t              state;
    logic [ADDR_W-1:0]   cur_addr;
    logic [LEN_W:0]      beats;
    logic [PIPE_N-1:0]   vld_p;
    logic [PIPE_N-1:0]   last_p;

    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    logic [DATA_W:0]     fifo_head;
    logic                fifo_push;
    logic                fifo_pop;

    logic [CNT_W:0]      in_flight;
    logic [CNT_W:0]      outstanding;
    logic                issue;
    logic                final_beat;

    function automatic logic [CNT_W:0] ones(input logic [PIPE_N-1:0] v);
        logic [CNT_W:0] n;
        n = '0;
        for (int i = 0; i < PIPE_N; i++) begin
            n = n + (CNT_W+1)'(v[i]);
        end
        return n;
    endfunction

    // Credit: every beat issued but not yet popped holds one FIFO slot, so
    // the FIFO can never be pushed while full.
    assign in_flight   = ones(vld_p);
    assign outstanding = in_flight + (CNT_W+1)'(fifo_count);
    assign issue       = (state == RD) && (outstanding < (CNT_W+1)'(RSP_DEPTH));
    assign final_beat  = (beats == (LEN_W+1)'(1));

    assign cmd_ready = (state == IDLE);
    assign wr_ready  = (state == WR);

    always_ff @(posedge clka_0 or negedge rsta_n_0) begin
        if (!rsta_n_0) begin
            state    <= IDLE;
            cur_addr <= '0;
            beats    <= '0;
            addra_0  <= '0;
            dina_0   <= '0;
            wea_0    <= 1'b0;
            vld_p    <= '0;
            last_p   <= '0;
        end else begin
            wea_0  <= 1'b0;
            // Issue -> address stage -> ... -> BRAM data stage.
            vld_p  <= {vld_p[PIPE_N-2:0], issue};
            last_p <= {last_p[PIPE_N-2:0], issue && final_beat};

            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cur_addr <= cmd_addr;
                        beats    <= {1'b0, cmd_len} + (LEN_W+1)'(1);
                        state    <= cmd_we ? WR : RD;
                    end
                end
                WR: begin
                    if (wr_valid) begin
                        addra_0  <= cur_addr;
                        dina_0   <= wr_data;
                        wea_0    <= 1'b1;
                        cur_addr <= cur_addr + ADDR_W'(1);
                        beats    <= beats - (LEN_W+1)'(1);
                        // Final pulse lands together with IDLE so the next
                        // command can be taken without a bubble.
                        if (final_beat) begin
                            state <= IDLE;
                        end
                    end
                end
                RD: begin
                    if (issue) begin
                        addra_0  <= cur_addr;
                        cur_addr <= cur_addr + ADDR_W'(1);
                        beats    <= beats - (LEN_W+1)'(1);
                        if (final_beat) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (in_flight == '0) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // BRAM data stage -> response FIFO.
    assign fifo_push = vld_p[PIPE_N-1];
    assign fifo_pop  = !fifo_empty && rsp_ready;

    rsp_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clka_0),
        .rst_n     (rsta_n_0),
        .push      (fifo_push),
        .push_data ({last_p[PIPE_N-1], douta_0}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign rsp_valid = !fifo_empty;
    assign rsp_data  = fifo_head[DATA_W-1:0];
    assign rsp_last  = fifo_head[DATA_W];
    assign busy      = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_bram_port_master.sv
// ---------------------------------------------------------------------------
// tb_bram_port_master
//   Bench for bram_port_master with a behavioural single-port BRAM (read
//   latency 1, read-first). A reference model tracks memory contents, the
//   expected BRAM write pulses and the expected response stream; a compare
//   process checks the DUT against it on every falling edge.
// ---------------------------------------------------------------------------
module tb_bram_port_master;

    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 16;
    localparam int LEN_W     = 4;
    localparam int RD_LAT    = 1;
    localparam int RSP_DEPTH = 4;
    localparam int MEM_N     = 1 << ADDR_W;

    logic              clka_0 = 1'b0;
    logic              rsta_n_0;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_last;
    logic              busy;
    logic [ADDR_W-1:0] addra_0;
    logic [DATA_W-1:0] dina_0;
    logic              wea_0;
    logic [DATA_W-1:0] douta_0;

    always #10 clka_0 = ~clka_0;

    bram_port_master #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .LEN_W     (LEN_W),
        .RD_LAT    (RD_LAT),
        .RSP_DEPTH (RSP_DEPTH)
    ) dut (
        .clka_0    (clka_0),
        .rsta_n_0  (rsta_n_0),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_last  (rsp_last),
        .busy      (busy),
        .addra_0   (addra_0),
        .dina_0    (dina_0),
        .wea_0     (wea_0),
        .douta_0   (douta_0)
    );

    // Behavioural BRAM, one cycle read latency.
    logic [DATA_W-1:0] bram [MEM_N];
    always @(posedge clka_0) begin
        if (wea_0) bram[addra_0] <= dina_0;
        douta_0 <= bram[addra_0];
    end

    // ------------------------------------------------------------ model
    typedef struct { int addr; int data; } wr_t;
    typedef struct { int data; int last; int cyc; } rsp_t;

    int   ref_mem [MEM_N];
    wr_t  exp_wr [$];
    rsp_t exp_rsp [$];
    wr_t  wlog [$];
    rsp_t rlog [$];
    int   m_addr = 0;
    int   m_wr_left = 0;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_chk = 0;
    int   rsp_mode = 0;
    bit   prev_hold = 0;
    int   prev_word = 0;
    int   wdata [$];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    always @(posedge clka_0) cyc++;

    always @(posedge clka_0) begin
        #1;
        case (rsp_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = 1'b0;
            default: rsp_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Compare process.
    always @(negedge clka_0) begin
        wr_t  w;
        rsp_t r;
        if (!rsta_n_0) begin
            prev_hold = 0;
        end else begin
            check("wr_ready", int'(wr_ready), int'(m_wr_left > 0));
            if (wea_0) begin
                check("wr_pending", int'(exp_wr.size() > 0), 1);
                if (exp_wr.size() > 0) begin
                    w = exp_wr.pop_front();
                    check("wr_addr", int'(addra_0), w.addr);
                    check("wr_data", int'(dina_0), w.data);
                end
                wlog.push_back('{int'(addra_0), int'(dina_0)});
            end
            if (prev_hold) begin
                check("rsp_hold_valid", int'(rsp_valid), 1);
                check("rsp_hold_word", int'({rsp_last, rsp_data}), prev_word);
            end
            prev_hold = rsp_valid && !rsp_ready;
            prev_word = int'({rsp_last, rsp_data});
            if (rsp_valid && rsp_ready) begin
                check("rsp_pending", int'(exp_rsp.size() > 0), 1);
                if (exp_rsp.size() > 0) begin
                    r = exp_rsp.pop_front();
                    check("rsp_data", int'(rsp_data), r.data);
                    check("rsp_last", int'(rsp_last), r.last);
                end
                rlog.push_back('{int'(rsp_data), int'(rsp_last), cyc});
            end
            if (wr_valid && wr_ready) begin
                exp_wr.push_back('{m_addr, int'(wr_data)});
                ref_mem[m_addr] = int'(wr_data);
                m_addr = (m_addr + 1) % MEM_N;
                m_wr_left--;
            end
            if (cmd_valid && cmd_ready) begin
                if (cmd_we) begin
                    m_addr    = int'(cmd_addr);
                    m_wr_left = int'(cmd_len) + 1;
                end else begin
                    for (int i = 0; i <= int'(cmd_len); i++)
                        exp_rsp.push_back('{ref_mem[(int'(cmd_addr) + i) % MEM_N],
                                            int'(i == int'(cmd_len)), 0});
                end
            end
        end
    end

    // ------------------------------------------------------------ stimulus
    task automatic tick(input int n);
        repeat (n) @(posedge clka_0);
        #1;
    endtask

    task automatic send_cmd(input bit we, input int addr, input int len);
        int t;
        t = 0;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = ADDR_W'(addr);
        cmd_len   = LEN_W'(len);
        @(negedge clka_0);
        while (!cmd_ready && t < 300) begin
            @(negedge clka_0);
            t++;
        end
        if (!cmd_ready) check("cmd_timeout", int'(cmd_ready), 1);
        @(posedge clka_0);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic send_beat(input int data, input int gap);
        int t;
        t = 0;
        wr_valid = 1'b0;
        if (gap > 0) tick(gap);
        wr_valid = 1'b1;
        wr_data  = DATA_W'(data);
        @(negedge clka_0);
        while (!wr_ready && t < 50) begin
            @(negedge clka_0);
            t++;
        end
        if (!wr_ready) check("beat_timeout", int'(wr_ready), 1);
        @(posedge clka_0);
        #1;
        wr_valid = 1'b0;
    endtask

    // Sends the contents of wdata as one write burst.
    task automatic write_burst(input int addr, input int gap_max, input bit toggle);
        send_cmd(1'b1, addr, wdata.size() - 1);
        foreach (wdata[i])
            send_beat(wdata[i], toggle ? 1 : int'($urandom_range(0, gap_max)));
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clka_0);
        while ((busy || exp_rsp.size() > 0) && t < 500) begin
            @(negedge clka_0);
            t++;
        end
        check("idle_busy", int'(busy), 0);
        tick(2);
        check("idle_rsp_left", exp_rsp.size(), 0);
        check("idle_wr_left", exp_wr.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addra"},     int'(addra_0),   0);
        check({tag, "_dina"},      int'(dina_0),    0);
        check({tag, "_wea"},       int'(wea_0),     0);
        check({tag, "_rsp_valid"}, int'(rsp_valid), 0);
        check({tag, "_rsp_last"},  int'(rsp_last),  0);
        check({tag, "_busy"},      int'(busy),      0);
        check({tag, "_cmd_ready"}, int'(cmd_ready), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        rsta_n_0  = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < MEM_N; i++) ref_mem[i] = 0;
        #5;
        check_reset_outputs("reset");
        check("reset_wr_ready", int'(wr_ready), 0);
        repeat (3) @(posedge clka_0);
        #1;
        rsta_n_0 = 1'b1;
        tick(1);

        // Fill every BRAM word so all later reads have known contents.
        for (int b = 0; b < MEM_N / 16; b++) begin
            wdata.delete();
            for (int i = 0; i < 16; i++) wdata.push_back(int'($urandom_range(0, 65535)));
            write_burst(b * 16, 0, 1'b0);
        end
        wait_idle();

        // Single beat write then read.
        wlog.delete(); rlog.delete();
        wdata = '{23};
        write_burst(2, 0, 1'b0);
        wait_idle();
        check("single_wr_count", wlog.size(), 1);
        if (wlog.size() >= 1) begin
            check("single_wr_addr", wlog[0].addr, 2);
            check("single_wr_data", wlog[0].data, 23);
        end
        send_cmd(1'b0, 2, 0);
        wait_idle();
        check("single_rd_count", rlog.size(), 1);
        if (rlog.size() >= 1) begin
            check("single_rd_data", rlog[0].data, 23);
            check("single_rd_last", rlog[0].last, 1);
        end

        // Three-beat burst, read back back-to-back.
        rlog.delete();
        wdata = '{50, 23, 45};
        write_burst(1, 0, 1'b0);
        wait_idle();
        send_cmd(1'b0, 1, 2);
        wait_idle();
        check("burst_rd_count", rlog.size(), 3);
        if (rlog.size() == 3) begin
            check("burst_d0", rlog[0].data, 50);
            check("burst_d1", rlog[1].data, 23);
            check("burst_d2", rlog[2].data, 45);
            check("burst_l0", rlog[0].last, 0);
            check("burst_l1", rlog[1].last, 0);
            check("burst_l2", rlog[2].last, 1);
            check("burst_gap01", rlog[1].cyc - rlog[0].cyc, 1);
            check("burst_gap12", rlog[2].cyc - rlog[1].cyc, 1);
        end

        // Address wrap at the top of memory.
        wlog.delete(); rlog.delete();
        wdata = '{7, 8, 9, 10};
        write_burst(1022, 0, 1'b0);
        wait_idle();
        check("wrap_wr_count", wlog.size(), 4);
        if (wlog.size() == 4) begin
            check("wrap_a0", wlog[0].addr, 1022);
            check("wrap_a1", wlog[1].addr, 1023);
            check("wrap_a2", wlog[2].addr, 0);
            check("wrap_a3", wlog[3].addr, 1);
        end
        send_cmd(1'b0, 1022, 3);
        wait_idle();
        check("wrap_rd_count", rlog.size(), 4);
        if (rlog.size() == 4) begin
            check("wrap_d2", rlog[2].data, 9);
            check("wrap_d3", rlog[3].data, 10);
        end

        // Backpressure: only RSP_DEPTH reads issue while rsp_ready is low.
        rlog.delete();
        rsp_mode = 1;
        tick(2);
        send_cmd(1'b0, 100, 15);
        tick(30);
        check("stall_addr", int'(addra_0), 100 + RSP_DEPTH - 1);
        check("stall_busy", int'(busy), 1);
        check("stall_rsp_valid", int'(rsp_valid), 1);
        check("stall_no_rsp", rlog.size(), 0);
        rsp_mode = 0;
        wait_idle();
        check("stall_rd_count", rlog.size(), 16);
        if (rlog.size() == 16) check("stall_last", rlog[15].last, 1);

        // Write beats offered every other cycle.
        wlog.delete();
        wdata.delete();
        for (int i = 0; i < 8; i++) wdata.push_back(1000 + i);
        write_burst(200, 0, 1'b1);
        wait_idle();
        check("toggle_wr_count", wlog.size(), 8);
        if (wlog.size() == 8) check("toggle_last_addr", wlog[7].addr, 207);

        // Randomized command mix with random response backpressure.
        rsp_mode = 2;
        for (int k = 0; k < 40; k++) begin
            int len;
            len = int'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                wdata.delete();
                for (int i = 0; i <= len; i++) wdata.push_back(int'($urandom_range(0, 65535)));
                write_burst(int'($urandom_range(0, MEM_N - 1)), 2, 1'b0);
            end else begin
                send_cmd(1'b0, int'($urandom_range(0, MEM_N - 1)), len);
            end
        end
        wait_idle();

        // Reset in the middle of a stalled read burst.
        rsp_mode = 1;
        tick(2);
        send_cmd(1'b0, 300, 15);
        tick(6);
        #4;
        rsta_n_0 = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_rsp.delete();
        exp_wr.delete();
        m_wr_left = 0;
        @(posedge clka_0);
        #1;
        rsta_n_0 = 1'b1;
        rsp_mode = 0;
        tick(2);
        check("midrst_idle_busy", int'(busy), 0);
        wlog.delete(); rlog.delete();
        wdata = '{16'h1234};
        write_burst(5, 0, 1'b0);
        wait_idle();
        send_cmd(1'b0, 5, 0);
        wait_idle();
        check("post_rst_wr_count", wlog.size(), 1);
        check("post_rst_rd_count", rlog.size(), 1);
        if (rlog.size() == 1) begin
            check("post_rst_data", rlog[0].data, 16'h1234);
            check("post_rst_last", rlog[0].last, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
